// File: rtl/branch_unit_ras.sv
// EX-stage branch resolver with a circular return-address stack; registered outputs, one-cycle latency.
// Optional BRANCH_STATS_EN adds branch and taken counters.
module branch_unit_ras #(
  parameter int ADDR_W    = 32,
  parameter int JADDR_W   = 26,
  parameter int RAS_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         flush,
  input  logic [5:0]                   opcode,
  input  logic [ADDR_W-1:0]            rs,
  input  logic [JADDR_W-1:0]           jaddr,
  input  logic [ADDR_W-1:0]            pc,
  input  logic                         carry_flag,
  input  logic                         zero_flag,
  input  logic                         overflow_flag,
  input  logic                         sign_flag,
  output logic                         out_valid,
  output logic                         pc_src,
  output logic [ADDR_W-1:0]            ex_npc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_ovf,
  output logic                         ras_unf
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]                  br_count,
  output logic [31:0]                  taken_count
`endif
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic              out_valid_q, out_valid_d;
  logic              pc_src_q, pc_src_d;
  logic [ADDR_W-1:0] ex_npc_q, ex_npc_d;
  logic [PW-1:0]     tp_q, tp_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [ADDR_W-1:0] stack_q [RAS_DEPTH];
  logic [ADDR_W-1:0] stack_d [RAS_DEPTH];

  logic              accept;
  logic              is_branch;
  logic              taken;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] next_pc;
  logic [PW-1:0]     pop_idx;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] taken_count_q, taken_count_d;
`endif

  always_comb begin
    accept    = in_valid & ~flush;
    is_branch = (opcode[5:4] == 2'b11);
    target    = ADDR_W'(jaddr);
    pop_idx   = tp_q - PW'(1);
    taken     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    next_pc   = target;
    if (accept && is_branch) begin
      case (opcode[3:0])
        4'b0000: taken = 1'b1;
        4'b0001: taken = zero_flag;
        4'b0010: taken = ~zero_flag;
        4'b0011: taken = carry_flag;
        4'b0100: taken = ~carry_flag;
        4'b0101: taken = sign_flag;
        4'b0110: taken = ~sign_flag;
        4'b0111: taken = overflow_flag;
        4'b1000: taken = ~overflow_flag;
        4'b1001: begin
          taken = 1'b1;
          push  = 1'b1;
        end
        4'b1100: begin
          taken   = 1'b1;
          next_pc = rs;
        end
        4'b1110: begin
          next_pc = stack_q[pop_idx];
          if (count_q != '0) begin
            taken = 1'b1;
            pop   = 1'b1;
          end
        end
        default: taken = 1'b0;
      endcase
    end
  end

  // Stack bookkeeping; a full stack wraps onto the oldest entry, an empty ret only raises the flag
  always_comb begin
    out_valid_d = accept;
    pc_src_d    = taken;
    ex_npc_d    = taken ? next_pc : '0;
    tp_d        = tp_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    stack_d     = stack_q;
    if (push) begin
      stack_d[tp_q] = pc + ADDR_W'(1);
      tp_d          = tp_q + PW'(1);
      if (count_q == CW'(RAS_DEPTH)) ovf_d = 1'b1;
      else count_d = count_q + CW'(1);
    end
    if (pop) begin
      tp_d    = pop_idx;
      count_d = count_q - CW'(1);
    end
    if (accept && is_branch && opcode[3:0] == 4'b1110 && count_q == '0) unf_d = 1'b1;
  end

`ifdef BRANCH_STATS_EN
  always_comb begin
    br_count_d    = br_count_q + 32'(accept && is_branch);
    taken_count_d = taken_count_q + 32'(taken);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      pc_src_q    <= 1'b0;
      ex_npc_q    <= '0;
      tp_q        <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) stack_q[i] <= '0;
`ifdef BRANCH_STATS_EN
      br_count_q    <= '0;
      taken_count_q <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      pc_src_q    <= pc_src_d;
      ex_npc_q    <= ex_npc_d;
      tp_q        <= tp_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      for (int i = 0; i < RAS_DEPTH; i++) stack_q[i] <= stack_d[i];
`ifdef BRANCH_STATS_EN
      br_count_q    <= br_count_d;
      taken_count_q <= taken_count_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign pc_src    = pc_src_q;
  assign ex_npc    = ex_npc_q;
  assign ras_count = count_q;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;
`ifdef BRANCH_STATS_EN
  assign br_count    = br_count_q;
  assign taken_count = taken_count_q;
`endif

endmodule

// File: tb/tb_branch_unit_ras.sv
// Directed self-checking bench for branch_unit_ras (RAS_DEPTH=8).
// Stats checks are compiled in when BRANCH_STATS_EN is defined.
module tb_branch_unit_ras;

  localparam logic [5:0] OP_B    = 6'b110000;
  localparam logic [5:0] OP_BZ   = 6'b110001;
  localparam logic [5:0] OP_BNZ  = 6'b110010;
  localparam logic [5:0] OP_BCY  = 6'b110011;
  localparam logic [5:0] OP_BV   = 6'b110111;
  localparam logic [5:0] OP_CALL = 6'b111001;
  localparam logic [5:0] OP_BR   = 6'b111100;
  localparam logic [5:0] OP_RET  = 6'b111110;
  localparam logic [5:0] OP_ALU  = 6'b000101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, flush;
  logic [5:0]  opcode;
  logic [31:0] rs, pc;
  logic [25:0] jaddr;
  logic        carry_flag, zero_flag, overflow_flag, sign_flag;
  logic        out_valid, pc_src, ras_ovf, ras_unf;
  logic [31:0] ex_npc;
  logic [3:0]  ras_count;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_count, taken_count;
`endif

  int tests = 0;
  int fails = 0;

  branch_unit_ras dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .flush(flush), .opcode(opcode),
    .rs(rs), .jaddr(jaddr), .pc(pc), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .overflow_flag(overflow_flag), .sign_flag(sign_flag), .out_valid(out_valid),
    .pc_src(pc_src), .ex_npc(ex_npc), .ras_count(ras_count), .ras_ovf(ras_ovf),
    .ras_unf(ras_unf)
`ifdef BRANCH_STATS_EN
    , .br_count(br_count), .taken_count(taken_count)
`endif
  );

  always #5 clk = ~clk;

  // flg is {C, Z, V, S}; returns 1 time unit after the capturing edge
  task automatic apply_stimulus(input logic v, input logic f, input logic [5:0] op,
                                input logic [31:0] r, input logic [25:0] ja,
                                input logic [31:0] p, input logic [3:0] flg);
    in_valid = v; flush = f; opcode = op; rs = r; jaddr = ja; pc = p;
    {carry_flag, zero_flag, overflow_flag, sign_flag} = flg;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; flush = 1'b0; opcode = '0; rs = '0; jaddr = '0; pc = '0;
    {carry_flag, zero_flag, overflow_flag, sign_flag} = 4'b0;
    #3;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b exp 0", out_valid); end
    tests++; if (pc_src !== 1'b0 || ex_npc !== 32'h0) begin fails++; $display("[TB] FAIL reset_pc: got %b/%h exp 0/0", pc_src, ex_npc); end
    tests++; if (ras_count !== 4'd0 || ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin fails++; $display("[TB] FAIL reset_ras: got %0d/%b/%b exp 0/0/0", ras_count, ras_ovf, ras_unf); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_branches();
    apply_stimulus(1, 0, OP_B, 32'h0, 26'h0000ABC, 32'h0, 4'b0000);
    tests++; if (out_valid !== 1'b1 || pc_src !== 1'b1 || ex_npc !== 32'h00000ABC) begin fails++; $display("[TB] FAIL b_uncond: got %b/%b/%h exp 1/1/00000abc", out_valid, pc_src, ex_npc); end
    apply_stimulus(1, 0, OP_BZ, 32'h0, 26'h30, 32'h0, 4'b0000);
    tests++; if (out_valid !== 1'b1 || pc_src !== 1'b0 || ex_npc !== 32'h0) begin fails++; $display("[TB] FAIL bz_not_taken: got %b/%b/%h exp 1/0/0", out_valid, pc_src, ex_npc); end
    apply_stimulus(1, 0, OP_BNZ, 32'h0, 26'h10, 32'h0, 4'b0000);
    tests++; if (pc_src !== 1'b1 || ex_npc !== 32'h10) begin fails++; $display("[TB] FAIL bnz_taken: got %b/%h exp 1/10", pc_src, ex_npc); end
    apply_stimulus(1, 0, OP_BCY, 32'h0, 26'h20, 32'h0, 4'b1000);
    tests++; if (pc_src !== 1'b1 || ex_npc !== 32'h20) begin fails++; $display("[TB] FAIL bcy_taken: got %b/%h exp 1/20", pc_src, ex_npc); end
    apply_stimulus(1, 0, OP_BV, 32'h0, 26'h24, 32'h0, 4'b1101);
    tests++; if (pc_src !== 1'b0 || ex_npc !== 32'h0) begin fails++; $display("[TB] FAIL bv_not_taken: got %b/%h exp 0/0", pc_src, ex_npc); end
    apply_stimulus(1, 0, OP_BR, 32'hDEADBEEF, 26'h44, 32'h0, 4'b0000);
    tests++; if (pc_src !== 1'b1 || ex_npc !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL br_rs: got %b/%h exp 1/deadbeef", pc_src, ex_npc); end
    apply_stimulus(1, 0, OP_ALU, 32'h0, 26'h55, 32'h0, 4'b1111);
    tests++; if (out_valid !== 1'b1 || pc_src !== 1'b0 || ex_npc !== 32'h0) begin fails++; $display("[TB] FAIL alu_op: got %b/%b/%h exp 1/0/0", out_valid, pc_src, ex_npc); end
    apply_stimulus(0, 0, OP_B, 32'h0, 26'h66, 32'h0, 4'b0000);
    tests++; if (out_valid !== 1'b0 || pc_src !== 1'b0 || ex_npc !== 32'h0) begin fails++; $display("[TB] FAIL idle: got %b/%b/%h exp 0/0/0", out_valid, pc_src, ex_npc); end
  endtask

  task automatic test_call_ret();
    apply_stimulus(1, 0, OP_CALL, 32'h0, 26'h200, 32'h100, 4'b0000);
    tests++; if (pc_src !== 1'b1 || ex_npc !== 32'h200 || ras_count !== 4'd1) begin fails++; $display("[TB] FAIL call: got %b/%h/%0d exp 1/200/1", pc_src, ex_npc, ras_count); end
    apply_stimulus(1, 0, OP_RET, 32'h0, 26'h0, 32'h200, 4'b0000);
    tests++; if (pc_src !== 1'b1 || ex_npc !== 32'h101 || ras_count !== 4'd0) begin fails++; $display("[TB] FAIL ret: got %b/%h/%0d exp 1/101/0", pc_src, ex_npc, ras_count); end
  endtask

  task automatic test_overflow_underflow();
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(1, 0, OP_CALL, 32'h0, 26'h40, 32'(i), 4'b0000);
      tests++; if (ras_count !== 4'((i < 8) ? i + 1 : 8) || ras_ovf !== (i == 8)) begin fails++; $display("[TB] FAIL call_fill_%0d: got count %0d ovf %b exp %0d/%b", i, ras_count, ras_ovf, (i < 8) ? i + 1 : 8, i == 8); end
    end
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(1, 0, OP_RET, 32'h0, 26'h0, 32'h0, 4'b0000);
      tests++; if (pc_src !== 1'b1 || ex_npc !== 32'(9 - k) || ras_count !== 4'(7 - k)) begin fails++; $display("[TB] FAIL ret_drain_%0d: got %b/%h/%0d exp 1/%h/%0d", k, pc_src, ex_npc, ras_count, 9 - k, 7 - k); end
    end
    apply_stimulus(1, 0, OP_RET, 32'h0, 26'h0, 32'h0, 4'b0000);
    tests++; if (out_valid !== 1'b1 || pc_src !== 1'b0 || ex_npc !== 32'h0) begin fails++; $display("[TB] FAIL ret_empty: got %b/%b/%h exp 1/0/0", out_valid, pc_src, ex_npc); end
    tests++; if (ras_unf !== 1'b1 || ras_ovf !== 1'b1 || ras_count !== 4'd0) begin fails++; $display("[TB] FAIL sticky_flags: got unf %b ovf %b count %0d exp 1/1/0", ras_unf, ras_ovf, ras_count); end
  endtask

  task automatic test_flush();
    apply_stimulus(1, 0, OP_CALL, 32'h0, 26'h300, 32'h50, 4'b0000);
    tests++; if (ras_count !== 4'd1) begin fails++; $display("[TB] FAIL flush_pre_call: got %0d exp 1", ras_count); end
    apply_stimulus(1, 1, OP_CALL, 32'h0, 26'h300, 32'h70, 4'b0000);
    tests++; if (out_valid !== 1'b0 || ras_count !== 4'd1 || pc_src !== 1'b0) begin fails++; $display("[TB] FAIL flush_call: got %b/%0d/%b exp 0/1/0", out_valid, ras_count, pc_src); end
    apply_stimulus(1, 0, OP_RET, 32'h0, 26'h0, 32'h0, 4'b0000);
    tests++; if (ex_npc !== 32'h51 || ras_count !== 4'd0) begin fails++; $display("[TB] FAIL flush_ret: got %h/%0d exp 51/0", ex_npc, ras_count); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) apply_stimulus(1, 0, OP_CALL, 32'h0, 26'h80, 32'(i), 4'b0000);
    tests++; if (ras_count !== 4'd3 || pc_src !== 1'b1) begin fails++; $display("[TB] FAIL mid_pre: got %0d/%b exp 3/1", ras_count, pc_src); end
    rst_n = 1'b0;
    #2;
    tests++; if (out_valid !== 1'b0 || pc_src !== 1'b0 || ex_npc !== 32'h0) begin fails++; $display("[TB] FAIL mid_reset_out: got %b/%b/%h exp 0/0/0", out_valid, pc_src, ex_npc); end
    tests++; if (ras_count !== 4'd0 || ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset_ras: got %0d/%b/%b exp 0/0/0", ras_count, ras_ovf, ras_unf); end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply_stimulus(1, 0, OP_RET, 32'h0, 26'h0, 32'h0, 4'b0000);
    tests++; if (pc_src !== 1'b0 || ras_unf !== 1'b1) begin fails++; $display("[TB] FAIL mid_reset_empty: got %b/%b exp 0/1", pc_src, ras_unf); end
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(1, 0, OP_B, 32'h0, 26'h10, 32'h0, 4'b0000);
    apply_stimulus(1, 0, OP_BZ, 32'h0, 26'h10, 32'h0, 4'b0000);
    apply_stimulus(1, 0, OP_BNZ, 32'h0, 26'h10, 32'h0, 4'b0000);
    apply_stimulus(1, 0, OP_ALU, 32'h0, 26'h10, 32'h0, 4'b0000);
    tests++; if (br_count !== 32'd3 || taken_count !== 32'd2) begin fails++; $display("[TB] FAIL stats: got %0d/%0d exp 3/2", br_count, taken_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_branches();
    test_call_ret();
    test_overflow_underflow();
    test_flush();
    test_reset_mid();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
